// File: rtl/record_field_unpacker_if.sv
// Bundles the record-input and field-output handshakes of record_field_unpacker.
// The unpacker connects through the slave modport and the environment through the master modport.
interface record_field_unpacker_if #(
  parameter int REC_WIDTH = 73,
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [REC_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [1:0]           out_field;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_field, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_field, out_last
  );
endinterface

// File: rtl/record_field_unpacker.sv
// Accepts one packed {w, x, y, z} record per handshake and streams its fields as four beats.
// Define RECORD_UNPACK_SEXT_EN to sign-extend fields to OUT_WIDTH instead of zero-extending them.
module record_field_unpacker #(
  parameter int W_WIDTH   = 32,
  parameter int X_WIDTH   = 32,
  parameter int Y_WIDTH   = 8,
  parameter int Z_WIDTH   = 1,
  parameter int OUT_WIDTH = 32,
  localparam int REC_WIDTH = W_WIDTH + X_WIDTH + Y_WIDTH + Z_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  record_field_unpacker_if.slave    bus,
  output logic [15:0]               rec_count
);

  generate
    if (OUT_WIDTH < W_WIDTH || OUT_WIDTH < X_WIDTH ||
        OUT_WIDTH < Y_WIDTH || OUT_WIDTH < Z_WIDTH) begin : g_width_check
      $error("record_field_unpacker: OUT_WIDTH must be >= every field width");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [REC_WIDTH-1:0]   hold_q, hold_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [1:0]             out_field_q, out_field_d;
  logic                   out_last_q, out_last_d;
  logic [15:0]            rec_count_q, rec_count_d;

  logic beat_fire;
  logic last_fire;
  logic accept;

  // Slices one field out of a packed record and widens it to the output bus.
  function automatic logic [OUT_WIDTH-1:0] field_ext(input logic [REC_WIDTH-1:0] rec,
                                                     input logic [1:0]           idx);
    logic [W_WIDTH-1:0] w;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic [Z_WIDTH-1:0] z;
    logic [OUT_WIDTH-1:0] result;
    w = rec[REC_WIDTH-1 -: W_WIDTH];
    x = rec[Y_WIDTH+Z_WIDTH +: X_WIDTH];
    y = rec[Z_WIDTH +: Y_WIDTH];
    z = rec[0 +: Z_WIDTH];
    result = '0;
    case (idx)
`ifdef RECORD_UNPACK_SEXT_EN
      2'd0:    result = OUT_WIDTH'($signed(w));
      2'd1:    result = OUT_WIDTH'($signed(x));
      2'd2:    result = OUT_WIDTH'($signed(y));
      default: result = OUT_WIDTH'($signed(z));
`else
      2'd0:    result = OUT_WIDTH'(w);
      2'd1:    result = OUT_WIDTH'(x);
      2'd2:    result = OUT_WIDTH'(y);
      default: result = OUT_WIDTH'(z);
`endif
    endcase
    return result;
  endfunction

  assign beat_fire    = out_valid_q & bus.out_ready;
  assign last_fire    = beat_fire & out_last_q;
  assign bus.in_ready = (state_q == IDLE) | last_fire;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_field_d = out_field_q;
    out_last_d  = out_last_q;
    rec_count_d = rec_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = EMIT;
          hold_d      = bus.in_data;
          out_valid_d = 1'b1;
          out_field_d = 2'd0;
          out_data_d  = field_ext(bus.in_data, 2'd0);
          out_last_d  = 1'b0;
        end
      end
      EMIT: begin
        if (beat_fire) begin
          if (out_last_q) begin
            rec_count_d = rec_count_q + 16'd1;
            // A record arriving with the last-beat handshake starts immediately, keeping 4 beats/record.
            if (accept) begin
              hold_d      = bus.in_data;
              out_field_d = 2'd0;
              out_data_d  = field_ext(bus.in_data, 2'd0);
              out_last_d  = 1'b0;
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
            end
          end else begin
            out_field_d = out_field_q + 2'd1;
            out_data_d  = field_ext(hold_q, out_field_q + 2'd1);
            out_last_d  = (out_field_q == 2'd2);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_field_q <= 2'd0;
      out_last_q  <= 1'b0;
      rec_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_field_q <= out_field_d;
      out_last_q  <= out_last_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_field = out_field_q;
  assign bus.out_last  = out_last_q;
  assign rec_count     = rec_count_q;

endmodule

// File: tb/tb_record_field_unpacker.sv
// Scoreboard bench for record_field_unpacker: expected beats are queued on accept and checked as they appear.
module tb_record_field_unpacker;

  localparam int OUT_WIDTH = 32;
  localparam int REC_WIDTH = 73;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rec_count;

  record_field_unpacker_if #(.REC_WIDTH(REC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  record_field_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rec_count (rec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  field;
    logic        last;
  } beat_t;

  beat_t       scoreboard[$];
  beat_t       front;
  int          pop_cyc[$];
  int          cycle_n = 0;
  logic [15:0] exp_count = 16'd0;
  logic [15:0] exp_base = 16'd0;
  int          checks = 0;
  int          passed = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Widens an n-bit field to 32 bits the way the consumer expects to see it.
  function automatic logic [31:0] ext(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v & ~({32{1'b1}} << n);
`ifdef RECORD_UNPACK_SEXT_EN
    if (v[n-1]) r = r | ({32{1'b1}} << n);
`endif
    return r;
  endfunction

  // Monitor runs mid-cycle, when both DUT outputs and bench inputs are settled for the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      scoreboard.delete();
      exp_count = 16'd0;
    end else begin
      cycle_n++;
      if (scoreboard.size() == 0) begin
        checkOutput("idle_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
      end else begin
        front = scoreboard[0];
        checkOutput("beat_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("beat_data", {32'd0, bus.out_data}, {32'd0, front.data});
        checkOutput("beat_field", {62'd0, bus.out_field}, {62'd0, front.field});
        checkOutput("beat_last", {63'd0, bus.out_last}, {63'd0, front.last});
        checkOutput("busy_in_ready", {63'd0, bus.in_ready}, {63'd0, front.last & bus.out_ready});
        if (bus.out_valid && bus.out_ready) begin
          void'(scoreboard.pop_front());
          pop_cyc.push_back(cycle_n);
          if (front.last) exp_count = exp_count + 16'd1;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        scoreboard.push_back('{ext(bus.in_data[72:41], 32), 2'd0, 1'b0});
        scoreboard.push_back('{ext(bus.in_data[40:9], 32), 2'd1, 1'b0});
        scoreboard.push_back('{ext({24'd0, bus.in_data[8:1]}, 8), 2'd2, 1'b0});
        scoreboard.push_back('{ext({31'd0, bus.in_data[0]}, 1), 2'd3, 1'b1});
      end
    end
  end

  // Presents one record and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] x,
                               input logic [7:0] y, input logic z);
    bit got;
    got = 0;
    bus.in_data  = {w, x, y, z};
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 200 && scoreboard.size() != 0; c++) @(posedge clk);
    checkOutput(tag, 64'(scoreboard.size()), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rec_count", {48'd0, rec_count}, {48'd0, 16'(exp_base + exp_count)});
  endtask

  int p0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset_out_data", {32'd0, bus.out_data}, 64'd0);
    checkOutput("reset_out_field", {62'd0, bus.out_field}, 64'd0);
    checkOutput("reset_out_last", {63'd0, bus.out_last}, 64'd0);
    checkOutput("reset_rec_count", {48'd0, rec_count}, 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Basic record with every field equal to one.
    applyStimulus(32'd1, 32'd1, 8'd1, 1'b1);
    waitDrain("t1_drain");
    checkOutput("t1_count", {48'd0, rec_count}, 64'd1);

    // All-ones record exercises the extension of the narrow fields.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 1'b1);
    waitDrain("t2_drain");

    // Consumer stalls for three cycles while beat 1 is presented.
    applyStimulus(32'd2, 32'd2, 8'd3, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    waitDrain("t3_drain");

    // Two records back to back must stream as eight beats with no bubble.
    p0 = pop_cyc.size();
    applyStimulus(32'hA5A5_0001, 32'h8000_0000, 8'h80, 1'b0);
    applyStimulus(32'h0000_7FFF, 32'h1234_5678, 8'h7F, 1'b1);
    waitDrain("t4_drain");
    checkOutput("t4_beats", 64'(pop_cyc.size() - p0), 64'd8);
    if (pop_cyc.size() >= p0 + 8)
      checkOutput("t4_no_bubble", 64'(pop_cyc[p0+7] - pop_cyc[p0]), 64'd7);

    // Reset lands mid-record; nothing of the old record may reappear afterwards.
    applyStimulus(32'd8, 32'd3, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("t5_out_data", {32'd0, bus.out_data}, 64'd0);
    checkOutput("t5_out_field", {62'd0, bus.out_field}, 64'd0);
    checkOutput("t5_out_last", {63'd0, bus.out_last}, 64'd0);
    checkOutput("t5_rec_count", {48'd0, rec_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(32'd5, 32'd6, 8'd7, 1'b1);
    waitDrain("t5_drain");

    // Counter wrap: preload the count to its maximum, then finish one more record.
    force dut.rec_count_q = 16'hFFFF;
    exp_base = 16'hFFFF - exp_count;
    @(posedge clk);
    #1;
    release dut.rec_count_q;
    @(posedge clk);
    #1;
    checkOutput("t6_preload", {48'd0, rec_count}, 64'hFFFF);
    applyStimulus(32'h0000_0042, 32'd9, 8'h11, 1'b0);
    waitDrain("t6_drain");
    checkOutput("t6_wrap", {48'd0, rec_count}, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
